uart_rx_cfg: RTL and testbench

Parametrised successor to the fixed 8N1 UART receiver used in the AXI4-Lite/UART bridge. It supports configurable data width, parity and stop bits. It adds an input synchroniser, false-start rejection, parity/framing/overrun detection, break handling, and a ready/valid output toward the RX FIFO. It sits between the i_Rx_Serial pin and fifoRx; its handshake replaces the bare o_RX_Done strobe.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/bit_sync.sv | 25 ++
 rtl/uart_rx_cfg.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and the parity helper
// used by both the configurable receiver and the future transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_t;

   localparam int PAR_NONE      = 0;
   localparam int PAR_ODD       = 1;
   localparam int PAR_EVEN      = 2;
   localparam int MAX_DATA_BITS = 9;

   // Parity bit a transmitter would send for this data; zero-extended data is harmless.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
      logic p;
      case (mode)
         PAR_ODD:  p = ~(^data);
         PAR_EVEN: p = ^data;
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 1 so an
// idle-high line never looks like a start bit coming out of reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the flop chain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{1'b1}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with false-start rejection, parity/framing/overrun
// detection, break handling and a ready/valid holding register toward the RX FIFO.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_Rx_Serial,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_CTS,
   output logic                 o_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   logic                     rx_s;
   rx_state_t                state_q, state_d;
   logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]     shreg_q, shreg_d;
   logic                     par_err_q, par_err_d;
   logic                     fr_err_q, fr_err_d;
   logic [DATA_BITS-1:0]     data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     perr_q, perr_d;
   logic                     ferr_q, ferr_d;
   logic                     overrun_q, overrun_d;
   logic                     complete_s;
   logic                     fr_now_s;
   logic [MAX_DATA_BITS-1:0] par_in_s;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (i_Rx_Serial),
      .q_o (rx_s)
   );

   // State, counters, shift register and holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         clk_cnt_q <= {CW{1'b0}};
         bit_cnt_q <= {BW{1'b0}};
         shreg_q   <= {DATA_BITS{1'b0}};
         par_err_q <= 1'b0;
         fr_err_q  <= 1'b0;
         data_q    <= {DATA_BITS{1'b0}};
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_err_q <= par_err_d;
         fr_err_q  <= fr_err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   // Frame FSM next state and word completion
   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_err_d  = par_err_q;
      fr_err_d   = fr_err_q;
      complete_s = 1'b0;
      fr_now_s   = fr_err_q | ~rx_s;
      par_in_s   = {MAX_DATA_BITS{1'b0}};
      par_in_s[DATA_BITS-1:0] = shreg_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               clk_cnt_d = {CW{1'b0}};
            end else begin
               clk_cnt_d = clk_cnt_q;
            end
         end
         START: begin
            if (clk_cnt_q == CNT_MID) begin
               clk_cnt_d = {CW{1'b0}};
               bit_cnt_d = {BW{1'b0}};
               par_err_d = 1'b0;
               fr_err_d  = 1'b0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = {CW{1'b0}};
               // After DATA_BITS shifts the first bit on the line lands in the LSB
               shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = {BW{1'b0}};
                  state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         PARITY: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = {CW{1'b0}};
               par_err_d = rx_s ^ parity_bit(par_in_s, PARITY_MODE);
               state_d   = STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = {CW{1'b0}};
               fr_err_d  = fr_now_s;
               if (bit_cnt_q == STOP_LAST) begin
                  complete_s = 1'b1;
                  bit_cnt_d  = {BW{1'b0}};
                  state_d    = rx_s ? IDLE : BRK_WAIT;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         BRK_WAIT: begin
            if (rx_s) begin
               state_d = IDLE;
            end else begin
               state_d = BRK_WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding register: load on completion unless a stalled word would be overwritten
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      overrun_d = 1'b0;
      if (complete_s) begin
         if (!valid_q || i_ready) begin
            data_d  = shreg_q;
            perr_d  = par_err_q;
            ferr_d  = fr_now_s;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
   assign o_overrun    = overrun_q;
   assign o_CTS        = !valid_q || i_ready;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both at 8 clocks per bit.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a, cts_a, busy_a;
   logic [7:0] data_a;
   logic       rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b, cts_b, busy_b;
   logic [6:0] data_b;

   uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .rst(rst), .i_Rx_Serial(rx_a), .i_ready(ready_a), .o_data(data_a), .o_valid(valid_a),
      .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a), .o_CTS(cts_a), .o_busy(busy_a));

   uart_rx_cfg #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .rst(rst), .i_Rx_Serial(rx_b), .i_ready(ready_b), .o_data(data_b), .o_valid(valid_b),
      .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overrun(ovr_b), .o_CTS(cts_b), .o_busy(busy_b));

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int st_a   = 0;

   int         xfer_a = 0, vcyc_a = 0, bcyc_a = 0, ocyc_a = 0, rise_a = 0;
   logic       prev_valid_a = 1'b0;
   logic [7:0] last_data_a = 8'h00;
   logic       last_perr_a = 1'b0, last_ferr_a = 1'b0;
   int         xfer_b = 0;
   logic [6:0] last_data_b = 7'h00;
   logic       last_perr_b = 1'b0, last_ferr_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe transfers and activity just before each rising edge
   always @(negedge clk) begin
      #3;
      if (valid_a && ready_a) begin
         xfer_a++;
         last_data_a = data_a;
         last_perr_a = perr_a;
         last_ferr_a = ferr_a;
      end
      if (valid_a) vcyc_a++;
      if (busy_a) bcyc_a++;
      if (ovr_a) ocyc_a++;
      if (valid_a && !prev_valid_a) rise_a = cyc;
      prev_valid_a = valid_a;
      if (valid_b && ready_b) begin
         xfer_b++;
         last_data_b = data_b;
         last_perr_b = perr_b;
         last_ferr_b = ferr_b;
      end
   end

   task automatic send_a(input logic [7:0] d);
      logic [9:0] fr;
      fr   = {1'b1, d, 1'b0};
      st_a = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_a = fr[i];
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic send_b(input logic [6:0] d, input logic p);
      logic [10:0] fr;
      fr = {2'b11, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_b = fr[i];
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({valid_a, perr_a, ferr_a, ovr_a, busy_a, cts_a} !== 6'b000001) begin
         fails++; $display("FAIL reset_ctrl_a: got %b expected 000001", {valid_a, perr_a, ferr_a, ovr_a, busy_a, cts_a});
      end
      checks++;
      if (data_a !== 8'h00) begin
         fails++; $display("FAIL reset_data_a: got %h expected 00", data_a);
      end
      checks++;
      if ({valid_b, perr_b, ferr_b, ovr_b, busy_b, cts_b, data_b} !== 13'b0000010000000) begin
         fails++; $display("FAIL reset_b: got %b expected 0000010000000", {valid_b, perr_b, ferr_b, ovr_b, busy_b, cts_b, data_b});
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic_8n1();
      logic [7:0] pats [2];
      int x0, v0;
      pats[0] = 8'hA5; pats[1] = 8'h3E;
      for (int k = 0; k < 2; k++) begin
         x0 = xfer_a; v0 = vcyc_a;
         send_a(pats[k]);
         repeat (8) @(negedge clk);
         checks++;
         if (xfer_a - x0 !== 1 || vcyc_a - v0 !== 1) begin
            fails++; $display("FAIL basic_pulse: got xfers %0d valid cycles %0d expected 1 and 1", xfer_a - x0, vcyc_a - v0);
         end
         checks++;
         if ({last_data_a, last_perr_a, last_ferr_a} !== {pats[k], 2'b00}) begin
            fails++; $display("FAIL basic_data: got %h/%b%b expected %h/00", last_data_a, last_perr_a, last_ferr_a, pats[k]);
         end
         checks++;
         if (rise_a - st_a !== 79) begin
            fails++; $display("FAIL basic_latency: got %0d cycles expected 79", rise_a - st_a);
         end
      end
   endtask

   task automatic test_parity_7e2();
      logic [6:0] dats [3];
      logic       pars [3];
      logic       exp_perr [3];
      int x0;
      dats[0] = 7'h55; pars[0] = 1'b1; exp_perr[0] = 1'b1;
      dats[1] = 7'h55; pars[1] = 1'b0; exp_perr[1] = 1'b0;
      dats[2] = 7'h07; pars[2] = 1'b1; exp_perr[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         x0 = xfer_b;
         send_b(dats[k], pars[k]);
         repeat (8) @(negedge clk);
         checks++;
         if (xfer_b - x0 !== 1) begin
            fails++; $display("FAIL parity_count: got %0d words expected 1", xfer_b - x0);
         end
         checks++;
         if ({last_data_b, last_perr_b, last_ferr_b} !== {dats[k], exp_perr[k], 1'b0}) begin
            fails++; $display("FAIL parity_word: got %h/%b%b expected %h/%b0", last_data_b, last_perr_b, last_ferr_b, dats[k], exp_perr[k]);
         end
      end
   endtask

   task automatic test_glitch();
      int b0, v0;
      b0 = bcyc_a; v0 = vcyc_a;
      rx_a = 1'b0;
      repeat (3) @(negedge clk);
      rx_a = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (bcyc_a - b0 !== 4) begin
         fails++; $display("FAIL glitch_busy: got %0d busy cycles expected 4", bcyc_a - b0);
      end
      checks++;
      if (vcyc_a - v0 !== 0 || busy_a !== 1'b0) begin
         fails++; $display("FAIL glitch_idle: got valid cycles %0d busy %b expected 0 and 0", vcyc_a - v0, busy_a);
      end
   endtask

   task automatic test_overrun();
      int x0, o0;
      ready_a = 1'b0;
      x0 = xfer_a; o0 = ocyc_a;
      send_a(8'h11);
      repeat (4) @(negedge clk);
      checks++;
      if ({valid_a, cts_a, data_a} !== {2'b10, 8'h11}) begin
         fails++; $display("FAIL ovr_hold1: got valid %b cts %b data %h expected 1 0 11", valid_a, cts_a, data_a);
      end
      send_a(8'h22);
      repeat (4) @(negedge clk);
      checks++;
      if (ocyc_a - o0 !== 1) begin
         fails++; $display("FAIL ovr_pulse: got %0d overrun cycles expected 1", ocyc_a - o0);
      end
      checks++;
      if ({valid_a, cts_a, data_a, perr_a, ferr_a} !== {2'b10, 8'h11, 2'b00}) begin
         fails++; $display("FAIL ovr_hold2: got valid %b cts %b data %h flags %b%b expected 1 0 11 00", valid_a, cts_a, data_a, perr_a, ferr_a);
      end
      @(negedge clk);
      ready_a = 1'b1;
      #1;
      checks++;
      if (cts_a !== 1'b1) begin
         fails++; $display("FAIL ovr_cts_drain: got %b expected 1", cts_a);
      end
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b0 || xfer_a - x0 !== 1 || last_data_a !== 8'h11) begin
         fails++; $display("FAIL ovr_drain: got valid %b xfers %0d data %h expected 0 1 11", valid_a, xfer_a - x0, last_data_a);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_break();
      int x0;
      x0 = xfer_a;
      rx_a = 1'b0;
      repeat (160) @(negedge clk);
      checks++;
      if (xfer_a - x0 !== 1 || {last_data_a, last_perr_a, last_ferr_a} !== {8'h00, 2'b01}) begin
         fails++; $display("FAIL break_word: got %0d words %h/%b%b expected 1 00/01", xfer_a - x0, last_data_a, last_perr_a, last_ferr_a);
      end
      checks++;
      if (busy_a !== 1'b1) begin
         fails++; $display("FAIL break_wait: got busy %b expected 1", busy_a);
      end
      rx_a = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || xfer_a - x0 !== 1) begin
         fails++; $display("FAIL break_release: got busy %b words %0d expected 0 1", busy_a, xfer_a - x0);
      end
      send_a(8'h3C);
      repeat (8) @(negedge clk);
      checks++;
      if (xfer_a - x0 !== 2 || {last_data_a, last_perr_a, last_ferr_a} !== {8'h3C, 2'b00}) begin
         fails++; $display("FAIL break_after: got %0d words %h/%b%b expected 2 3c/00", xfer_a - x0, last_data_a, last_perr_a, last_ferr_a);
      end
   endtask

   task automatic test_reset_mid_frame();
      int x0;
      x0 = xfer_a;
      rx_a = 1'b0;
      repeat (8) @(negedge clk);
      rx_a = 1'b1;
      repeat (16) @(negedge clk);
      checks++;
      if (busy_a !== 1'b1) begin
         fails++; $display("FAIL midrst_busy: got %b expected 1", busy_a);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({valid_a, perr_a, ferr_a, ovr_a, busy_a, cts_a, data_a} !== {6'b000001, 8'h00}) begin
         fails++; $display("FAIL midrst_outputs: got %b expected 00000100000000", {valid_a, perr_a, ferr_a, ovr_a, busy_a, cts_a, data_a});
      end
      rst = 1'b0;
      repeat (16) @(negedge clk);
      checks++;
      if (xfer_a - x0 !== 0 || vcyc_a < 0) begin
         fails++; $display("FAIL midrst_noword: got %0d words expected 0", xfer_a - x0);
      end
      send_a(8'h81);
      repeat (8) @(negedge clk);
      checks++;
      if (xfer_a - x0 !== 1 || {last_data_a, last_perr_a, last_ferr_a} !== {8'h81, 2'b00}) begin
         fails++; $display("FAIL midrst_after: got %0d words %h/%b%b expected 1 81/00", xfer_a - x0, last_data_a, last_perr_a, last_ferr_a);
      end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_parity_7e2();
      test_glitch();
      test_overrun();
      test_break();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
